dm_sized_wait: RTL

// - Parametrised byte-addressed data memory for the CPU datapath: byte/half/word loads and stores,

---
 rtl/dm_sized_wait_pkg.sv | 31 +++
 rtl/dm_sized_wait_if.sv | 34 +++
 rtl/dm_sized_wait_load_fmt.sv | 32 +++
 rtl/dm_sized_wait.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dm_sized_wait_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_pkg
//  Description : Shared definitions for the sized wait-state data memory:
//                access-size codes, FSM state encoding and a byte-count helper.
//  Revision    : 1.0  initial release
// ============================================================================
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of bytes touched by an access of the given size.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_sized_wait_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_sized_wait_if
//  Description : Request/response bus between the CPU datapath (master) and
//                the data memory (slave).
//                Request : MemAddr, MemWriteData, MemWrite, MemRead, MemSize,
//                          MemUnsigned
//                Response: MemReadData, MemReady, MemErr
//  Revision    : 1.0  initial release
// ============================================================================
interface dm_sized_wait_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [1:0]        MemSize;
    logic              MemUnsigned;
    logic [31:0]       MemReadData;
    logic              MemReady;
    logic              MemErr;

    modport master (
        output MemAddr, MemWriteData, MemWrite, MemRead, MemSize, MemUnsigned,
        input  MemReadData, MemReady, MemErr
    );

    modport slave (
        input  MemAddr, MemWriteData, MemWrite, MemRead, MemSize, MemUnsigned,
        output MemReadData, MemReady, MemErr
    );
endinterface
`default_nettype wire

// File: rtl/dm_sized_wait_load_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : dm_load_fmt
//  Description : Combinational load formatter. Takes four big-endian raw
//                bytes (i_raw[31:24] is the byte at the access address) and
//                returns the right-justified, sign/zero-extended result.
//  Ports       : i_raw      raw bytes M[a], M[a+1], M[a+2], M[a+3]
//                i_size     access size code
//                i_unsigned 1 zero-extend, 0 sign-extend (ignored for words)
//                o_data     formatted 32-bit load result
//  Revision    : 1.0  initial release
// ============================================================================
module dm_load_fmt
    import dm_pkg::*;
(
    input  wire logic [31:0] i_raw,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_unsigned,
    output logic      [31:0] o_data
);

    always_comb begin
        o_data = i_raw;
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & i_raw[31]}}, i_raw[31:24]};
            SZ_HALF: o_data = {{16{~i_unsigned & i_raw[31]}}, i_raw[31:16]};
            default: o_data = i_raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dm_sized_wait.sv
`default_nettype none
// ============================================================================
//  Module      : dm_sized_wait
//  Description : Byte-addressed big-endian data memory with byte/half/word
//                access, sign/zero-extended loads, LATENCY wait states and
//                error reporting for illegal, misaligned or out-of-range
//                requests.
//  Ports       : clk  clock
//                rst  synchronous active-high reset
//                bus  dm_sized_wait_if slave modport (request in, response out)
//  Revision    : 1.0  initial release
// ============================================================================
module dm_sized_wait
    import dm_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dm_sized_wait_if.slave  bus
);

    localparam int         c_AW      = $clog2(DEPTH);
    localparam logic [3:0] c_LAT_M1  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit         c_NO_WAIT = (LATENCY == 0);

    logic [7:0]      r_mem [DEPTH];

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [c_AW-1:0] r_addr;
    logic [31:0]     r_wdata;
    logic [1:0]      r_size;
    logic            r_uns;
    logic            r_write;
    logic            r_err;
    logic [31:0]     r_rdata;
    logic            r_ready;
    logic            r_mem_err;

    // ------------------------------------------------------------------
    // Request decode and error check (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic [c_AW-1:0] w_addr_low;
    logic            w_upper_nz;
    logic [31:0]     w_end;
    logic            w_misalign;
    logic            w_req;
    logic            w_err;

    assign w_addr_low = bus.MemAddr[c_AW-1:0];

    generate
        if (ADDR_W > c_AW) begin : g_upper
            assign w_upper_nz = |bus.MemAddr[ADDR_W-1:c_AW];
        end else begin : g_no_upper
            assign w_upper_nz = 1'b0;
        end
    endgenerate

    assign w_end      = 32'(w_addr_low) + 32'(size_bytes(bus.MemSize));
    assign w_misalign = ((bus.MemSize == SZ_HALF) && bus.MemAddr[0]) ||
                        ((bus.MemSize == SZ_WORD) && (bus.MemAddr[1:0] != 2'b00));
    assign w_req      = bus.MemRead | bus.MemWrite;
    // Every error class has the same outcome, so the checks simply OR together.
    assign w_err      = (bus.MemRead & bus.MemWrite) || (bus.MemSize == SZ_BAD) ||
                        w_misalign || w_upper_nz || (w_end > 32'(DEPTH));

    // ------------------------------------------------------------------
    // Load path: in IDLE the live request feeds the zero-latency case,
    // otherwise the latched request is used.
    // ------------------------------------------------------------------
    logic [c_AW-1:0] w_ra0;
    logic [1:0]      w_rsize;
    logic            w_runs;
    logic [31:0]     w_raw;
    logic [31:0]     w_fmt;

    assign w_ra0   = (r_state == ST_IDLE) ? w_addr_low      : r_addr;
    assign w_rsize = (r_state == ST_IDLE) ? bus.MemSize     : r_size;
    assign w_runs  = (r_state == ST_IDLE) ? bus.MemUnsigned : r_uns;
    assign w_raw   = {r_mem[w_ra0], r_mem[w_ra0 + c_AW'(1)],
                      r_mem[w_ra0 + c_AW'(2)], r_mem[w_ra0 + c_AW'(3)]};

    dm_load_fmt u_fmt (
        .i_raw      (w_raw),
        .i_size     (w_rsize),
        .i_unsigned (w_runs),
        .o_data     (w_fmt)
    );

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_size    <= SZ_BYTE;
            r_uns     <= 1'b0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_ready   <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready   <= 1'b0;
                    r_mem_err <= 1'b0;
                    if (w_req) begin
                        r_addr  <= w_addr_low;
                        r_wdata <= bus.MemWriteData;
                        r_size  <= bus.MemSize;
                        r_uns   <= bus.MemUnsigned;
                        r_write <= bus.MemWrite;
                        r_err   <= w_err;
                        if (w_err || c_NO_WAIT) begin
                            r_state   <= ST_DONE;
                            r_ready   <= 1'b1;
                            r_mem_err <= w_err;
                            r_rdata   <= (w_err || bus.MemWrite) ? 32'd0 : w_fmt;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_LAT_M1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= ST_DONE;
                        r_ready   <= 1'b1;
                        r_mem_err <= 1'b0;
                        r_rdata   <= r_write ? 32'd0 : w_fmt;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_ready   <= 1'b0;
                    r_mem_err <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ready   <= 1'b0;
                    r_mem_err <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store lanes: committed on the edge that ends DONE; the array itself
    // is never reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_DONE) && r_write && !r_err) begin
            case (r_size)
                SZ_BYTE: r_mem[r_addr] <= r_wdata[7:0];
                SZ_HALF: begin
                    r_mem[r_addr]             <= r_wdata[15:8];
                    r_mem[r_addr + c_AW'(1)]  <= r_wdata[7:0];
                end
                default: begin
                    r_mem[r_addr]             <= r_wdata[31:24];
                    r_mem[r_addr + c_AW'(1)]  <= r_wdata[23:16];
                    r_mem[r_addr + c_AW'(2)]  <= r_wdata[15:8];
                    r_mem[r_addr + c_AW'(3)]  <= r_wdata[7:0];
                end
            endcase
        end
    end

    assign bus.MemReadData = r_rdata;
    assign bus.MemReady    = r_ready;
    assign bus.MemErr      = r_mem_err;

endmodule
`default_nettype wire
